// File: rtl/xor_accum.sv
// Frame XOR accumulator: folds every beat of a frame into one word, with beat count and overflow flag.
// Define XOR_ACCUM_B2B_EN to accept the next frame's first beat in the same cycle the result is consumed.
module xor_accum #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_err
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // valid, once raised, is held with its payload until that transfer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // All block state in one record so checkers can bind to a single signal.
    typedef struct packed {
        state_t           state;
        logic [WIDTH-1:0] acc;
        logic [CW-1:0]    count;
        logic             err;
    } fsm_t;

    fsm_t cur;
    fsm_t nx;
    logic accept;
    logic consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else begin
            cur <= nx;
        end
    end

    always_comb begin
        in_ready = 1'b1;
        if (cur.state == HOLD) begin
`ifdef XOR_ACCUM_B2B_EN
            in_ready = out_ready;
`else
            in_ready = 1'b0;
`endif
        end
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (cur.state == HOLD);
    assign consume   = out_valid && out_ready;

    always_comb begin
        nx = cur;
        case (cur.state)
            IDLE: begin
                if (accept) begin
                    nx.acc   = in_data;
                    nx.count = CW'(1);
                    nx.err   = 1'b0;
                    nx.state = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    nx.acc = cur.acc ^ in_data;
                    // Past MAX_LEN the count pins and the frame is flagged, but data still folds in.
                    if (cur.count == CW'(MAX_LEN)) begin
                        nx.err = 1'b1;
                    end else begin
                        nx.count = cur.count + CW'(1);
                    end
                    nx.state = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (consume) begin
                    nx = '0;
                    // accept can only be high here when back-to-back operation is built in.
                    if (accept) begin
                        nx.acc   = in_data;
                        nx.count = CW'(1);
                        nx.err   = 1'b0;
                        nx.state = in_last ? HOLD : ACC;
                    end
                end
            end
            default: begin
                nx = '0;
            end
        endcase
    end

    always_comb begin
        out_data  = '0;
        out_count = '0;
        out_err   = 1'b0;
        if (out_valid) begin
            out_data  = cur.acc;
            out_count = cur.count;
            out_err   = cur.err;
        end
    end

    assign out_parity = ^out_data;

endmodule

// File: tb/tb_xor_accum.sv
// Bench for xor_accum (WIDTH=8, MAX_LEN=4): directed frames plus randomized frames against a frame-level model.
module tb_xor_accum;

  localparam int W  = 8;
  localparam int ML = 4;
  localparam int CW = $clog2(ML + 1);
  localparam int EW = W + CW + 1;

  typedef logic [W-1:0] beat_q_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_parity;
  logic [CW-1:0] out_count;
  logic          out_err;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  bit rand_ready_en = 1'b0;
  logic [EW-1:0] exp_q[$];

  xor_accum #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .out_count(out_count), .out_err(out_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // frame-level reference: XOR of all beats, length capped at ML, error when longer than ML
  function automatic logic [EW-1:0] model_frame(input beat_q_t beats);
    logic [W-1:0] x;
    int n;
    x = '0;
    n = beats.size();
    foreach (beats[i]) x = x ^ beats[i];
    return {(n > ML), CW'((n > ML) ? ML : n), x};
  endfunction

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cycle = cycle + 1;
    end
  endtask

  task automatic ready_randomizer();
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // scoreboard: every consumed result is popped from exp_q; idle outputs must read zero
  task automatic scoreboard_monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got data=%h count=%0d err=%b required no result", out_data, out_count, out_err);
          end else begin
            e = exp_q.pop_front();
            if ({out_err, out_count, out_data} !== e || out_parity !== ^e[W-1:0]) begin
              bad++;
              $display("FAIL sb_result got err=%b count=%0d data=%h par=%b required err=%b count=%0d data=%h par=%b",
                       out_err, out_count, out_data, out_parity, e[W+CW], e[W+CW-1:W], e[W-1:0], ^e[W-1:0]);
            end
          end
        end else if (!out_valid) begin
          total++;
          if (out_data !== '0 || out_count !== '0 || out_err !== 1'b0 || out_parity !== 1'b0) begin
            bad++;
            $display("FAIL sb_idle_zero got data=%h count=%0d err=%b par=%b required zeros",
                     out_data, out_count, out_err, out_parity);
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    #500000;
    $display("FAIL watchdog got time limit reached required completion");
    $fatal(1, "watchdog expired");
  endtask

  // driver tasks
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int waits;
    waits = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    #1;
    while (!in_ready && waits < 60) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_beat_timeout got in_ready=0 required 1 within 60 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = W'($urandom);
    in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input beat_q_t beats, input bit expect_result);
    if (expect_result) exp_q.push_back(model_frame(beats));
    foreach (beats[i]) send_beat(beats[i], (i == beats.size() - 1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_last = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, out_data, out_parity, out_count, out_err} !== {1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%h par=%b cnt=%0d err=%b required 1 0 00 0 0 0",
               in_ready, out_valid, out_data, out_parity, out_count, out_err);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    beat_q_t b;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    b = '{8'h0F, 8'hF0, 8'h3C};
    exp_q.push_back(model_frame(b));
    send_beat(8'h0F, 1'b0);
    send_beat(8'hF0, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid got %b required 0", out_valid);
    end
    send_beat(8'h3C, 1'b1);
    total++;
    if ({out_valid, out_data, out_parity, out_count, out_err} !== {1'b1, 8'hC3, 1'b0, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL basic_result got vld=%b data=%h par=%b cnt=%0d err=%b required 1 c3 0 3 0",
               out_valid, out_data, out_parity, out_count, out_err);
    end
    wait_drain();
  endtask

  task automatic test_single();
    beat_q_t b;
    b = '{8'hA5};
    send_frame(b, 1'b1);
    total++;
    if ({out_valid, out_data, out_parity, out_count, out_err} !== {1'b1, 8'hA5, 1'b0, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL single_result got vld=%b data=%h par=%b cnt=%0d err=%b required 1 a5 0 1 0",
               out_valid, out_data, out_parity, out_count, out_err);
    end
    wait_drain();
  endtask

  task automatic test_overflow();
    beat_q_t b;
    b = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_frame(b, 1'b1);
    total++;
    if ({out_valid, out_data, out_count, out_err} !== {1'b1, 8'h00, 3'd4, 1'b1}) begin
      bad++;
      $display("FAIL overflow6 got vld=%b data=%h cnt=%0d err=%b required 1 00 4 1",
               out_valid, out_data, out_count, out_err);
    end
    wait_drain();
    // exactly ML beats is not an error; ML+1 is
    for (int len = ML; len <= ML + 1; len++) begin
      b = {};
      for (int i = 0; i < len; i++) b.push_back(W'($urandom));
      send_frame(b, 1'b1);
      total++;
      if (out_err !== (len > ML) || out_count !== CW'(ML)) begin
        bad++;
        $display("FAIL overflow_edge len=%0d got err=%b cnt=%0d required err=%b cnt=%0d",
                 len, out_err, out_count, (len > ML), ML);
      end
      wait_drain();
    end
  endtask

  task automatic test_stall();
    beat_q_t b;
    logic [W-1:0] d0;
    logic [CW-1:0] c0;
    logic e0;
    out_ready = 1'b0;
    b = '{W'($urandom), W'($urandom), W'($urandom)};
    send_frame(b, 1'b1);
    d0 = out_data;
    c0 = out_count;
    e0 = out_err;
    exp_q.push_back(model_frame('{8'h77}));
    in_valid = 1'b1;
    in_data = 8'h77;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_count !== c0 || out_err !== e0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got vld=%b data=%h cnt=%0d err=%b rdy=%b required 1 %h %0d %b 0",
                 i, out_valid, out_data, out_count, out_err, in_ready, d0, c0, e0);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(8'h77, 1'b1);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    beat_q_t b;
    out_ready = 1'b1;
    send_beat(W'($urandom), 1'b0);
    send_beat(W'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state got rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    b = '{8'h11};
    send_frame(b, 1'b1);
    total++;
    if (out_data !== 8'h11 || out_count !== 3'd1 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_frame got data=%h cnt=%0d err=%b required 11 1 0", out_data, out_count, out_err);
    end
    wait_drain();
    // an unconsumed result is dropped by reset
    out_ready = 1'b0;
    b = '{8'h5A};
    send_frame(b, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hold_drop got vld=%b data=%h rdy=%b required 0 00 1", out_valid, out_data, in_ready);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    beat_q_t b;
    int t0;
    int t1;
    logic exp_rdy;
    int exp_gap;
`ifdef XOR_ACCUM_B2B_EN
    exp_rdy = 1'b1;
    exp_gap = 1;
`else
    exp_rdy = 1'b0;
    exp_gap = 2;
`endif
    out_ready = 1'b1;
    b = '{8'h12};
    exp_q.push_back(model_frame(b));
    b = '{8'h34};
    exp_q.push_back(model_frame(b));
    send_beat(8'h12, 1'b1);
    t0 = cycle;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h12 || in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL b2b_first got vld=%b data=%h rdy=%b required 1 12 %b", out_valid, out_data, in_ready, exp_rdy);
    end
    send_beat(8'h34, 1'b1);
    t1 = cycle;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h34 || (t1 - t0) !== exp_gap) begin
      bad++;
      $display("FAIL b2b_second got vld=%b data=%h gap=%0d required 1 34 %0d", out_valid, out_data, t1 - t0, exp_gap);
    end
    wait_drain();
  endtask

  task automatic test_random();
    beat_q_t b;
    int len;
    rand_ready_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      b = {};
      len = $urandom_range(1, ML + 3);
      for (int i = 0; i < len; i++) b.push_back(W'($urandom));
      send_frame(b, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2;
    wait_drain();
  endtask

  initial begin
    fork
      cycle_counter();
      ready_randomizer();
      scoreboard_monitor();
      watchdog();
    join_none
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
